// File: rtl/m_st7789_rcv.sv
// ST7789 SPI receiver: samples SCL/SDA/DC, assembles bytes and decodes CASET/RASET/RAMWR
// into pixel write strobes with a {y,x} address and frame bookkeeping.
module m_st7789_rcv #(
    parameter int unsigned W_MAX   = 239,
    parameter int unsigned H_MAX   = 239,
    parameter int unsigned IDLE_TO = 16
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        i_scl,
    input  logic        i_sda,
    input  logic        i_dc,
    input  logic        i_res,
    output logic        o_byte_valid,
    output logic [8:0]  o_byte,
    output logic [7:0]  o_cmd,
    output logic        o_we,
    output logic [15:0] o_waddr,
    output logic [15:0] o_wdata,
    output logic        o_frame_done,
    output logic [15:0] o_frame_cnt,
    output logic        o_err
);

    typedef enum logic [2:0] {StIdle, StCaset, StRaset, StRamwr, StOther} state_e;

    localparam logic [15:0] IdleLast = 16'(IDLE_TO - 1);
    localparam logic [15:0] IdleSat  = 16'(IDLE_TO);

    logic scl_s1_q, scl_s2_q, scl_s3_q;
    logic sda_s1_q, sda_s2_q;
    logic dc_s1_q, dc_s2_q;
    logic res_s1_q, res_s2_q;
    logic clr;

    // Display reset acts like w_rst on everything except the frame counter
    assign clr = w_rst | ~res_s2_q;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            res_s1_q <= 1'b1;
            res_s2_q <= 1'b1;
        end else begin
            res_s1_q <= i_res;
            res_s2_q <= res_s1_q;
        end
    end

    always_ff @(posedge w_clk) begin
        if (clr) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_s3_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            dc_s1_q  <= 1'b0;
            dc_s2_q  <= 1'b0;
        end else begin
            scl_s1_q <= i_scl;
            scl_s2_q <= scl_s1_q;
            scl_s3_q <= scl_s2_q;
            sda_s1_q <= i_sda;
            sda_s2_q <= sda_s1_q;
            dc_s1_q  <= i_dc;
            dc_s2_q  <= dc_s1_q;
        end
    end

    // Byte assembly
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        err_q, err_d;
    logic        byte_valid_q, byte_valid_d;
    logic [8:0]  byte_q, byte_d;
    logic        fall;

    assign fall = scl_s3_q & ~scl_s2_q;

    always_comb begin
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = 16'd0;
        err_d        = 1'b0;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        if (scl_s2_q) begin
            idle_cnt_d = (idle_cnt_q == IdleSat) ? idle_cnt_q : idle_cnt_q + 16'd1;
        end
        if (fall) begin
            sr_d      = {sr_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_d       = {dc_s2_q, sr_q[6:0], sda_s2_q};
            end
        end else if (scl_s2_q && bit_cnt_q != 3'd0 && idle_cnt_q == IdleLast) begin
            bit_cnt_d = 3'd0;
            err_d     = 1'b1;
        end
    end

    // Command/data decoder
    state_e      state_q, state_d;
    logic [2:0]  param_idx_q, param_idx_d;
    logic [7:0]  win_lo_q, win_lo_d;
    logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  pix_hi_q, pix_hi_d;
    logic        hi_valid_q, hi_valid_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        we_q, we_d;
    logic [15:0] waddr_q, waddr_d, wdata_q, wdata_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  rx_byte;

    assign rx_byte = byte_d[7:0];

    always_comb begin
        state_d      = state_q;
        param_idx_d  = param_idx_q;
        win_lo_d     = win_lo_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_hi_d     = pix_hi_q;
        hi_valid_d   = hi_valid_q;
        cmd_d        = cmd_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (byte_valid_d) begin
            if (!byte_d[8]) begin
                cmd_d       = rx_byte;
                param_idx_d = 3'd0;
                hi_valid_d  = 1'b0;
                case (rx_byte)
                    8'h2A: state_d = StCaset;
                    8'h2B: state_d = StRaset;
                    8'h2C: begin
                        state_d = StRamwr;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    default: state_d = StOther;
                endcase
            end else begin
                case (state_q)
                    StCaset, StRaset: begin
                        if (param_idx_q != 3'd4) param_idx_d = param_idx_q + 3'd1;
                        if (param_idx_q == 3'd1) win_lo_d = rx_byte;
                        // Window only changes once the end-low byte completes it
                        if (param_idx_q == 3'd3) begin
                            if (state_q == StCaset) begin
                                xs_d = win_lo_q;
                                xe_d = rx_byte;
                            end else begin
                                ys_d = win_lo_q;
                                ye_d = rx_byte;
                            end
                        end
                    end
                    StRamwr: begin
                        if (!hi_valid_q) begin
                            pix_hi_d   = rx_byte;
                            hi_valid_d = 1'b1;
                        end else begin
                            hi_valid_d = 1'b0;
                            we_d       = 1'b1;
                            wdata_d    = {pix_hi_q, rx_byte};
                            waddr_d    = {y_q, x_q};
                            if (x_q == xe_q) begin
                                x_d = xs_q;
                                if (y_q == ye_q) begin
                                    y_d          = ys_q;
                                    frame_done_d = 1'b1;
                                    frame_cnt_d  = frame_cnt_q + 16'd1;
                                end else begin
                                    y_d = y_q + 8'd1;
                                end
                            end else begin
                                x_d = x_q + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (clr) begin
            sr_q         <= 8'd0;
            bit_cnt_q    <= 3'd0;
            idle_cnt_q   <= 16'd0;
            err_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_q       <= 9'd0;
            state_q      <= StIdle;
            param_idx_q  <= 3'd0;
            win_lo_q     <= 8'd0;
            xs_q         <= 8'd0;
            xe_q         <= 8'(W_MAX);
            ys_q         <= 8'd0;
            ye_q         <= 8'(H_MAX);
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            pix_hi_q     <= 8'd0;
            hi_valid_q   <= 1'b0;
            cmd_q        <= 8'd0;
            we_q         <= 1'b0;
            waddr_q      <= 16'd0;
            wdata_q      <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            err_q        <= err_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            state_q      <= state_d;
            param_idx_q  <= param_idx_d;
            win_lo_q     <= win_lo_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_hi_q     <= pix_hi_d;
            hi_valid_q   <= hi_valid_d;
            cmd_q        <= cmd_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            frame_cnt_q <= 16'd0;
        end else if (res_s2_q) begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_byte_valid = byte_valid_q;
    assign o_byte       = byte_q;
    assign o_cmd        = cmd_q;
    assign o_we         = we_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;
    assign o_frame_done = frame_done_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err        = err_q;

endmodule

// File: doc/m_st7789_rcv.md
M_ST7789_RCV -- requirements
Module: m_st7789_rcv

Interface
REQ-001 SHALL have parameter W_MAX, default 239: reset-default column end (XE).
REQ-002 SHALL have parameter H_MAX, default 239: reset-default row end (YE).
REQ-003 SHALL have parameter IDLE_TO, default 16: SCL-high clock count after which a partial byte is dropped.
REQ-004 w_clk  in  1  system clock (100MHz); all logic on posedge.
REQ-005 w_rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 i_scl  in  1  SPI clock from display driver; idles high.
REQ-007 i_sda  in  1  SPI data, MSB first.
REQ-008 i_dc  in  1  data/command select (0=command, 1=data).
REQ-009 i_res  in  1  display reset; active-low.
REQ-010 o_byte_valid  out  1  one-cycle pulse per received byte.
REQ-011 o_byte  out  9  {dc, data[7:0]} of the last received byte.
REQ-012 o_cmd  out  8  last command byte received.
REQ-013 o_we  out  1  one-cycle pixel write strobe.
REQ-014 o_waddr  out  16  pixel address {y[7:0], x[7:0]}.
REQ-015 o_wdata  out  16  RGB565 pixel, first byte in [15:8].
REQ-016 o_frame_done  out  1  one-cycle pulse on the write to (XE,YE).
REQ-017 o_frame_cnt  out  16  completed-frame counter; wraps 0xFFFF->0.
REQ-018 o_err  out  1  one-cycle pulse when a partial byte is dropped.

Function
REQ-019 i_scl, i_sda, i_dc SHALL each pass two synchronizer flops; SCL edge detection SHALL use a third stage; all later timing refers to synchronized signals.
REQ-020 Sampling: on each detected SCL falling edge (cycle T) SHALL shift SDA into an 8-bit shift register and increment a 3-bit bit counter; DC SHALL be captured on the 8th sample.
REQ-021 Rising SCL edges SHALL cause no action.
REQ-022 On the 8th sample at cycle T: o_byte_valid=1 and o_byte updated at T+1; bit counter wraps to 0.
REQ-023 Idle timeout: bit counter !=0 and SCL high for IDLE_TO consecutive cycles -> counter cleared, bits discarded, o_err pulse; no o_byte_valid.
REQ-024 Decoder states: IDLE, CASET, RASET, RAMWR, OTHER.
REQ-025 Command byte (dc=0): o_cmd <= byte; 0x2A->CASET, 0x2B->RASET, 0x2C->RAMWR, else OTHER; param index cleared; pending pixel high byte discarded.
REQ-026 CASET/RASET: parameters 0..3 = start hi, start lo, end hi, end lo; only lo bytes kept (8 bits); params 4+ ignored; new window takes effect when param 3 arrives.
REQ-027 Entering RAMWR: x<=XS, y<=YS, byte phase <= high.
REQ-028 RAMWR data: high byte latched; low byte -> o_we=1 at T+1 with o_wdata={hi,lo}, o_waddr={y,x}.
REQ-029 Address advance after each write: x==XE -> x<=XS, y++; x==XE and y==YE -> x<=XS, y<=YS, o_frame_done=1 same cycle as o_we, o_frame_cnt++.
REQ-030 Data bytes in IDLE or OTHER SHALL be ignored (o_byte_valid still pulses).
REQ-031 XS>XE or YS>YE: x/y SHALL still increment modulo 256 until equality with XE/YE.
REQ-032 Outputs o_we, o_frame_done, o_err, o_byte_valid SHALL never be high more than one consecutive cycle per event.

Reset
REQ-033 w_rst=1: all outputs 0, state IDLE, XS=YS=0, XE=W_MAX, YE=H_MAX, x=y=0, bit counter 0, synchronizers to idle (SCL=1, SDA=1, DC=0).
REQ-034 i_res=0 (synchronized) SHALL act as w_rst except o_frame_cnt is retained; reset mid-byte or mid-pixel discards partial data with no o_err.

Verification
REQ-035 Byte 0x9C, dc=1, via mode-2 SPI -> single o_byte_valid, o_byte=0x19C.
REQ-036 Commands 0x2A{00,02,00,03}, 0x2B{00,05,00,05}, 0x2C, then 4 pixels 0x1234,0xABCD,0x0F0F,0xF0F0 -> writes at 0x0502,0x0503,0x0502,0x0503; o_frame_done with write 2 and write 4; o_frame_cnt=2.
REQ-037 After reset, 0x2C plus 57600 pixels -> last write address 0xEFEF, one o_frame_done, next pixel at 0x0000.
REQ-038 5 bits sent then SCL held high 16 cycles -> one o_err, no o_byte_valid; next full byte 0x55 received correctly.
REQ-039 0x2C, one high byte, then command 0x00 -> no o_we; o_cmd=0x00.
REQ-040 i_res low mid-RAMWR frame -> o_we stops, window default, o_frame_cnt unchanged.
